// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM state codes, parity types, vote helper.
// Latency: n/a (package). Backpressure: n/a.
// Consumers import uart_rx_pkg::* for a single source of encodings.
package uart_rx_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef struct packed {
        logic par_en;
        logic par_typ;
        logic stop2;
    } rx_cfg_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// RX line synchroniser, per-bit oversampling counter and 2-of-3 majority sampler.
// Latency: SYNC_STAGES cycles to line; sample_bit/sample_strobe valid at edge_cnt = P/2+1.
// Backpressure: none; the counter free-runs while run is high and holds at 0 otherwise.
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESC_W     = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx_in,
    input  logic [PRESC_W-1:0] presc,
    input  logic               run,
    output logic               line,
    output logic               bit_end,
    output logic               sample_bit,
    output logic               sample_strobe
);

    localparam logic [PRESC_W-1:0] ONE = PRESC_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [PRESC_W-1:0]     edge_cnt;
    logic [PRESC_W-1:0]     half;
    logic                   s0_q;
    logic                   s1_q;

    // presc arrives already forced even and >= 4
    assign half = {1'b0, presc[PRESC_W-1:1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
        end
    end

    assign line    = sync_q[SYNC_STAGES-1];
    assign bit_end = (edge_cnt == presc - ONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt <= '0;
            s0_q     <= 1'b1;
            s1_q     <= 1'b1;
        end else begin
            if (!run || bit_end) begin
                edge_cnt <= '0;
            end else begin
                edge_cnt <= edge_cnt + ONE;
            end
            if (run && edge_cnt == half - ONE) s0_q <= line;
            if (run && edge_cnt == half)       s1_q <= line;
        end
    end

    assign sample_strobe = run && (edge_cnt == half + ONE);
    assign sample_bit    = maj3(s0_q, s1_q, line);

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive controller: frame FSM, LSB-first deserialiser, parity and stop checks.
// Latency: data_valid/par_err/stp_err pulse 2 cycles after the final stop-bit decision point.
// Backpressure: none; results are single-cycle pulses the consumer must take when presented.
module uart_rx_frame_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int PRESC_W     = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [PRESC_W-1:0]    prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  stop2,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
);

    localparam int             BCW      = $clog2(DATA_WIDTH + 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

    logic [2:0]            state_q, state_d;
    logic [PRESC_W-1:0]    presc_q, presc_eff;
    rx_cfg_t               cfg_q;
    logic [BCW-1:0]        bit_cnt_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  par_bad_q, stp_bad_q, armed_q;
    logic                  line, bit_end, sample_bit, sample_strobe;
    logic                  run, start_det, par_exp;
    logic                  dv_d, pe_d, se_d;

    // Odd ratios drop their LSB; anything under 4 runs at 4 so the counter can never stall
    assign presc_eff = (prescale[PRESC_W-1:2] == '0) ? PRESC_W'(4)
                                                     : {prescale[PRESC_W-1:1], 1'b0};

    assign run       = (state_q == START) || (state_q == DATA) ||
                       (state_q == PARITY) || (state_q == STOP);
    // armed_q demands a 1 on the line since the last start, so a held break cannot retrigger
    assign start_det = (state_q == IDLE) && armed_q && !line;
    assign par_exp   = (cfg_q.par_typ == PAR_EVEN) ? ^shift_q : ~^shift_q;

    uart_rx_sampler #(
        .PRESC_W     (PRESC_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sampler (
        .clk           (clk),
        .rst           (rst),
        .rx_in         (rx_in),
        .presc         (presc_q),
        .run           (run),
        .line          (line),
        .bit_end       (bit_end),
        .sample_bit    (sample_bit),
        .sample_strobe (sample_strobe)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (start_det) state_d = START;
            START:  if (sample_strobe && sample_bit) state_d = IDLE;
                    else if (bit_end)                state_d = DATA;
            DATA:   if (bit_end && bit_cnt_q == LAST_BIT)
                        state_d = cfg_q.par_en ? PARITY : STOP;
            PARITY: if (bit_end) state_d = STOP;
            // the frame ends at the mid-point of the last stop bit
            STOP:   if (sample_strobe && (!cfg_q.stop2 || bit_cnt_q != '0)) state_d = DONE;
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        dv_d = 1'b0;
        pe_d = 1'b0;
        se_d = 1'b0;
        if (state_q == DONE) begin
            dv_d = !par_bad_q && !stp_bad_q;
            pe_d = par_bad_q;
            se_d = stp_bad_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q   <= PRESC_W'(4);
            cfg_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_bad_q <= 1'b0;
            stp_bad_q <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            if (start_det) begin
                presc_q   <= presc_eff;
                cfg_q     <= '{par_en: par_en, par_typ: par_typ, stop2: stop2};
                par_bad_q <= 1'b0;
                stp_bad_q <= 1'b0;
            end
            if (start_det) begin
                armed_q <= 1'b0;
            end else if (line && (state_q == IDLE || state_q == STOP || state_q == DONE)) begin
                armed_q <= 1'b1;
            end
            if (!run || state_d != state_q) begin
                bit_cnt_q <= '0;
            end else if (bit_end) begin
                bit_cnt_q <= bit_cnt_q + BCW'(1);
            end
            if (state_q == DATA && sample_strobe) begin
                shift_q <= {sample_bit, shift_q[DATA_WIDTH-1:1]};
            end
            if (state_q == PARITY && sample_strobe) begin
                par_bad_q <= (sample_bit != par_exp);
            end
            if (state_q == STOP && sample_strobe && !sample_bit) begin
                stp_bad_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data    <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            data_valid <= dv_d;
            par_err    <= pe_d;
            stp_err    <= se_d;
            if (dv_d) rx_data <= shift_q;
        end
    end

endmodule
